// File: rtl/ctrl_capture_6_if.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_capture_6_if
//  Description : Bus bundle for the ctrl_capture_6 event recorder.
//                master = stimulus / readback consumer, slave = recorder.
//  Signals     : en, counter, x, rd_idx        (master -> slave)
//                rd_time, rd_value, n_events,
//                full, overflow, armed         (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ctrl_capture_6_if #(
  parameter int WIDTH = 64
);
  logic             en;
  logic [11:0]      counter;
  logic [WIDTH-1:0] x;
  logic [2:0]       rd_idx;
  logic [11:0]      rd_time;
  logic [WIDTH-1:0] rd_value;
  logic [2:0]       n_events;
  logic             full;
  logic             overflow;
  logic             armed;

  modport master (
    output en, counter, x, rd_idx,
    input  rd_time, rd_value, n_events, full, overflow, armed
  );

  modport slave (
    input  en, counter, x, rd_idx,
    output rd_time, rd_value, n_events, full, overflow, armed
  );
endinterface
`default_nettype wire

// File: rtl/ctrl_capture_6.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_capture_6
//  Description : Event recorder for piecewise-constant control signals.
//                Captures a baseline value plus up to NEV change events as
//                (time, value) pairs, where time = counter+1 so a captured
//                pair can be replayed directly by a schedule generator.
//  Ports       : clk          - system clock, rising edge
//                sta          - synchronous active-high reset
//                bus (slave)  - en/counter/x sample inputs, rd_idx readback
//                               select, rd_time/rd_value registered readback,
//                               n_events/full/overflow/armed status
//  Options     : CTRL_CAPTURE_LSB_MASK_EN - ignore x[MASK_LSB-1:0] when
//                detecting changes (stored values stay full width)
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_capture_6 #(
  parameter int WIDTH    = 64,
  parameter int NEV      = 6,
  parameter int MASK_LSB = 8
) (
  input  logic             clk,
  input  logic             sta,
  ctrl_capture_6_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FULL  = 2'd2
  } state_t;

`ifdef CTRL_CAPTURE_LSB_MASK_EN
  localparam bit c_MASK_EN = 1'b1;
`else
  localparam bit c_MASK_EN = 1'b0;
`endif

  // Bits that participate in change detection; all ones when masking is off.
  localparam logic [WIDTH-1:0] c_CMP_MASK =
    c_MASK_EN ? ({WIDTH{1'b1}} << MASK_LSB) : {WIDTH{1'b1}};

  localparam logic [2:0] c_LAST_FREE = 3'(NEV - 1);
  localparam logic [2:0] c_MAX_IDX   = 3'(NEV);

  state_t           r_state;
  state_t           w_next;

  logic [11:0]      r_time [0:NEV];
  logic [WIDTH-1:0] r_val  [0:NEV];
  logic [WIDTH-1:0] r_prev;
  logic [2:0]       r_n_events;
  logic             r_overflow;
  logic [11:0]      r_rd_time;
  logic [WIDTH-1:0] r_rd_value;

  logic             w_diff;
  logic             w_base;
  logic             w_wr;
  logic             w_ovf;
  logic [2:0]       w_wr_idx;
  logic [11:0]      w_time_next;

  assign w_diff      = |((bus.x ^ r_prev) & c_CMP_MASK);
  assign w_wr_idx    = r_n_events + 3'd1;
  assign w_time_next = bus.counter + 12'd1;   // wraps 4095 -> 0 naturally

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sta) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and datapath strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    w_base = 1'b0;
    w_wr   = 1'b0;
    w_ovf  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.en) begin
          w_base = 1'b1;
          w_next = S_ARMED;
        end
      end
      S_ARMED: begin
        if (bus.en && w_diff) begin
          w_wr = 1'b1;
          if (r_n_events == c_LAST_FREE) begin
            w_next = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (bus.en && w_diff) begin
          w_ovf = 1'b1;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Slot storage, previous-value tracker and status
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sta) begin
      for (int i = 0; i <= NEV; i++) begin
        r_time[i] <= 12'd0;
        r_val[i]  <= '0;
      end
      r_prev     <= '0;
      r_n_events <= 3'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_base) begin
        r_time[0] <= 12'd0;
        r_val[0]  <= bus.x;
        r_prev    <= bus.x;
      end
      if (w_wr) begin
        r_time[w_wr_idx] <= w_time_next;
        r_val[w_wr_idx]  <= bus.x;
        r_prev           <= bus.x;
        r_n_events       <= w_wr_idx;
      end
      if (w_ovf) begin
        r_overflow <= 1'b1;
        r_prev     <= bus.x;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered readback; a same-cycle write is seen one cycle later.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sta) begin
      r_rd_time  <= 12'd0;
      r_rd_value <= '0;
    end else if (bus.rd_idx <= c_MAX_IDX) begin
      r_rd_time  <= r_time[bus.rd_idx];
      r_rd_value <= r_val[bus.rd_idx];
    end else begin
      r_rd_time  <= 12'd0;
      r_rd_value <= '0;
    end
  end

  assign bus.rd_time  = r_rd_time;
  assign bus.rd_value = r_rd_value;
  assign bus.n_events = r_n_events;
  assign bus.full     = (r_state == S_FULL);
  assign bus.overflow = r_overflow;
  assign bus.armed    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ctrl_capture_6.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_capture_6
//  Description : Directed self-checking bench for ctrl_capture_6.
//                Honours CTRL_CAPTURE_LSB_MASK_EN for the mask scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_capture_6;

  logic clk = 1'b0;
  logic sta = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  ctrl_capture_6_if #(.WIDTH(64)) bus ();

  ctrl_capture_6 #(.WIDTH(64), .NEV(6), .MASK_LSB(8)) dut (
    .clk (clk),
    .sta (sta),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] A = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] B = 64'hBFF8_0000_0000_0001;
  localparam logic [63:0] C = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] D = 64'h8000_0000_0000_0000;

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic e, input logic [11:0] c, input logic [63:0] v);
    bus.en      = e;
    bus.counter = c;
    bus.x       = v;
    @(posedge clk);
    #1;
  endtask

  task automatic read_slot(input logic [2:0] idx, output logic [11:0] t,
                           output logic [63:0] v);
    bus.en     = 1'b0;
    bus.rd_idx = idx;
    @(posedge clk);
    #1;
    t = bus.rd_time;
    v = bus.rd_value;
  endtask

  task automatic do_reset();
    sta = 1'b1;
    drive(1'b0, 12'd0, 64'd0);
    sta = 1'b0;
  endtask

  task automatic test_reset();
    bus.rd_idx = 3'd0;
    do_reset();
    n_checks++; if (bus.n_events !== 3'd0) begin n_errors++; $display("FAIL reset_n_events got %0d want 0", bus.n_events); end
    n_checks++; if (bus.full !== 1'b0) begin n_errors++; $display("FAIL reset_full got %b want 0", bus.full); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
    n_checks++; if (bus.armed !== 1'b0) begin n_errors++; $display("FAIL reset_armed got %b want 0", bus.armed); end
    n_checks++; if (bus.rd_time !== 12'd0) begin n_errors++; $display("FAIL reset_rd_time got %0d want 0", bus.rd_time); end
    n_checks++; if (bus.rd_value !== 64'd0) begin n_errors++; $display("FAIL reset_rd_value got %h want 0", bus.rd_value); end
  endtask

  task automatic test_baseline_events();
    logic [11:0] t;
    logic [63:0] v;
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      bus.rd_idx = (c == 10 || c == 11) ? 3'd1 : 3'd0;
      drive(1'b1, 12'(c), (c < 10) ? A : (c < 25) ? B : C);
      if (c == 0) begin
        n_checks++; if (bus.armed !== 1'b1) begin n_errors++; $display("FAIL base_armed got %b want 1", bus.armed); end
      end
      if (c == 10) begin
        n_checks++; if (bus.n_events !== 3'd1) begin n_errors++; $display("FAIL base_latency_n got %0d want 1", bus.n_events); end
        n_checks++; if (bus.rd_value !== 64'd0) begin n_errors++; $display("FAIL base_same_cycle_read got %h want 0", bus.rd_value); end
      end
      if (c == 11) begin
        n_checks++; if (bus.rd_value !== B) begin n_errors++; $display("FAIL base_read_next got %h want %h", bus.rd_value, B); end
      end
    end
    n_checks++; if (bus.n_events !== 3'd2) begin n_errors++; $display("FAIL base_n_events got %0d want 2", bus.n_events); end
    n_checks++; if (bus.full !== 1'b0) begin n_errors++; $display("FAIL base_full got %b want 0", bus.full); end
    read_slot(3'd0, t, v);
    n_checks++; if (t !== 12'd0 || v !== A) begin n_errors++; $display("FAIL base_slot0 got (%0d,%h) want (0,%h)", t, v, A); end
    read_slot(3'd1, t, v);
    n_checks++; if (t !== 12'd11 || v !== B) begin n_errors++; $display("FAIL base_slot1 got (%0d,%h) want (11,%h)", t, v, B); end
    read_slot(3'd2, t, v);
    n_checks++; if (t !== 12'd26 || v !== C) begin n_errors++; $display("FAIL base_slot2 got (%0d,%h) want (26,%h)", t, v, C); end
    read_slot(3'd3, t, v);
    n_checks++; if (t !== 12'd0 || v !== 64'd0) begin n_errors++; $display("FAIL base_slot3_empty got (%0d,%h) want (0,0)", t, v); end
  endtask

  // Consecutive-cycle changes fill the slots and then overflow.
  task automatic test_back_to_back();
    logic [11:0] t;
    logic [63:0] v;
    do_reset();
    drive(1'b1, 12'd0, 64'h1000);
    for (int i = 1; i <= 7; i++) begin
      drive(1'b1, 12'(i), 64'h1000 + 64'(i));
      if (i == 6) begin
        n_checks++; if (bus.n_events !== 3'd6) begin n_errors++; $display("FAIL fill_n_events got %0d want 6", bus.n_events); end
        n_checks++; if (bus.full !== 1'b1) begin n_errors++; $display("FAIL fill_full got %b want 1", bus.full); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_errors++; $display("FAIL fill_no_overflow got %b want 0", bus.overflow); end
      end
    end
    n_checks++; if (bus.overflow !== 1'b1) begin n_errors++; $display("FAIL fill_overflow got %b want 1", bus.overflow); end
    n_checks++; if (bus.n_events !== 3'd6) begin n_errors++; $display("FAIL fill_n_after_ovf got %0d want 6", bus.n_events); end
    for (int s = 1; s <= 6; s++) begin
      read_slot(3'(s), t, v);
      n_checks++;
      if (t !== 12'(s + 1) || v !== 64'h1000 + 64'(s)) begin
        n_errors++;
        $display("FAIL fill_slot%0d got (%0d,%h) want (%0d,%h)", s, t, v, s + 1, 64'h1000 + 64'(s));
      end
    end
    drive(1'b1, 12'd8, 64'h1000);
    n_checks++; if (bus.overflow !== 1'b1 || bus.full !== 1'b1) begin n_errors++; $display("FAIL fill_sticky got ovf=%b full=%b want 1/1", bus.overflow, bus.full); end
  endtask

  task automatic test_qualifier();
    logic [11:0] t;
    logic [63:0] v;
    do_reset();
    drive(1'b1, 12'd30, A);
    drive(1'b0, 12'd31, B);
    drive(1'b0, 12'd32, A);
    drive(1'b0, 12'd33, B);
    n_checks++; if (bus.n_events !== 3'd0) begin n_errors++; $display("FAIL qual_en0 got %0d want 0", bus.n_events); end
    drive(1'b1, 12'd34, A);
    drive(1'b1, 12'd35, A);
    n_checks++; if (bus.n_events !== 3'd0) begin n_errors++; $display("FAIL qual_same got %0d want 0", bus.n_events); end
    drive(1'b1, 12'd40, B);
    n_checks++; if (bus.n_events !== 3'd1) begin n_errors++; $display("FAIL qual_event got %0d want 1", bus.n_events); end
    read_slot(3'd1, t, v);
    n_checks++; if (t !== 12'd41 || v !== B) begin n_errors++; $display("FAIL qual_slot1 got (%0d,%h) want (41,%h)", t, v, B); end
  endtask

  task automatic test_wrap();
    logic [11:0] t;
    logic [63:0] v;
    do_reset();
    drive(1'b1, 12'd4094, A);
    drive(1'b1, 12'd4095, C);
    read_slot(3'd1, t, v);
    n_checks++; if (t !== 12'd0 || v !== C) begin n_errors++; $display("FAIL wrap_slot1 got (%0d,%h) want (0,%h)", t, v, C); end
    read_slot(3'd7, t, v);
    n_checks++; if (t !== 12'd0 || v !== 64'd0) begin n_errors++; $display("FAIL wrap_idx7 got (%0d,%h) want (0,0)", t, v); end
  endtask

  task automatic test_reset_mid();
    logic [11:0] t;
    logic [63:0] v;
    do_reset();
    drive(1'b1, 12'd50, A);
    drive(1'b1, 12'd51, B);
    drive(1'b1, 12'd52, C);
    drive(1'b1, 12'd53, A);
    bus.rd_idx = 3'd1;
    sta = 1'b1;
    drive(1'b1, 12'd54, D);
    sta = 1'b0;
    n_checks++;
    if (bus.n_events !== 3'd0 || bus.armed !== 1'b0 || bus.full !== 1'b0 ||
        bus.overflow !== 1'b0 || bus.rd_time !== 12'd0 || bus.rd_value !== 64'd0) begin
      n_errors++;
      $display("FAIL mid_reset got n=%0d armed=%b full=%b ovf=%b rt=%0d rv=%h want all 0",
               bus.n_events, bus.armed, bus.full, bus.overflow, bus.rd_time, bus.rd_value);
    end
    read_slot(3'd1, t, v);
    n_checks++; if (t !== 12'd0 || v !== 64'd0) begin n_errors++; $display("FAIL mid_slot1_cleared got (%0d,%h) want (0,0)", t, v); end
    drive(1'b1, 12'd100, D);
    n_checks++; if (bus.armed !== 1'b1 || bus.n_events !== 3'd0) begin n_errors++; $display("FAIL mid_rebase got armed=%b n=%0d want 1/0", bus.armed, bus.n_events); end
    read_slot(3'd0, t, v);
    n_checks++; if (t !== 12'd0 || v !== D) begin n_errors++; $display("FAIL mid_slot0 got (%0d,%h) want (0,%h)", t, v, D); end
  endtask

  task automatic test_mask();
    logic [11:0] t;
    logic [63:0] v;
    do_reset();
    drive(1'b1, 12'd200, 64'h4000_0000_0000_0100);
    drive(1'b1, 12'd201, 64'h4000_0000_0000_01AB);
    drive(1'b1, 12'd202, 64'h4000_0000_0000_00AB);
`ifdef CTRL_CAPTURE_LSB_MASK_EN
    n_checks++; if (bus.n_events !== 3'd1) begin n_errors++; $display("FAIL mask_n got %0d want 1", bus.n_events); end
    read_slot(3'd1, t, v);
    n_checks++; if (t !== 12'd203 || v !== 64'h4000_0000_0000_00AB) begin n_errors++; $display("FAIL mask_slot1 got (%0d,%h) want (203,40000000000000ab)", t, v); end
`else
    n_checks++; if (bus.n_events !== 3'd2) begin n_errors++; $display("FAIL nomask_n got %0d want 2", bus.n_events); end
    read_slot(3'd1, t, v);
    n_checks++; if (t !== 12'd202 || v !== 64'h4000_0000_0000_01AB) begin n_errors++; $display("FAIL nomask_slot1 got (%0d,%h) want (202,40000000000001ab)", t, v); end
    read_slot(3'd2, t, v);
    n_checks++; if (t !== 12'd203 || v !== 64'h4000_0000_0000_00AB) begin n_errors++; $display("FAIL nomask_slot2 got (%0d,%h) want (203,40000000000000ab)", t, v); end
`endif
  endtask

  initial begin
    bus.en      = 1'b0;
    bus.counter = 12'd0;
    bus.x       = 64'd0;
    bus.rd_idx  = 3'd0;
    test_reset();
    test_baseline_events();
    test_back_to_back();
    test_qualifier();
    test_wrap();
    test_reset_mid();
    test_mask();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
